// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and limits for the Gray counter and its consumers.
// The helpers work at GRAY_MAX_WIDTH; callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;
  localparam int GRAY_MAX_DIV   = 256;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A zero-extended Gray code decodes to the zero-extended binary value.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_cnt_prescale.sv
// Enable divider for the Gray counter: asserts step on every DIV-th enabled cycle.
// step is combinational from the prescaler state and en; the parent registers its effect.
module gray_cnt_prescale
  import gray_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int PW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_nxt;
  logic          at_last;

  assign at_last = (pre_q == LAST);
  assign step    = en && at_last;

  always_comb begin
    pre_nxt = pre_q;
    if (clr) begin
      pre_nxt = '0;
    end else if (en) begin
      pre_nxt = at_last ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_nxt;
    end
  end

endmodule

// File: rtl/gray_cnt.sv
// Up/down Gray-code counter with prescaler, sync clear/load and a binary monitor.
// Build option GRAY_CNT_SAT_EN: saturate at the ends instead of wrapping.
module gray_cnt
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b_mon,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic             step;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] g_q;
  logic             tick_q;
  logic             tick_nxt;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             at_end;

  // clr and load both restart the prescale period.
  gray_cnt_prescale #(
    .DIV (DIV)
  ) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | load),
    .en    (en),
    .step  (step)
  );

  assign at_end = up ? (b_q == CNT_MAX) : (b_q == '0);

  always_comb begin
    b_nxt    = b_q;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (clr) begin
      b_nxt = '0;
    end else if (load) begin
      b_nxt = load_val;
    end else if (step) begin
`ifdef GRAY_CNT_SAT_EN
      if (!at_end) begin
        b_nxt    = up ? b_q + 1'b1 : b_q - 1'b1;
        tick_nxt = 1'b1;
      end
`else
      b_nxt    = up ? b_q + 1'b1 : b_q - 1'b1;
      tick_nxt = 1'b1;
      wrap_nxt = at_end;
`endif
    end
  end

  // Gray is encoded from b_nxt so both registers load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      g_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_nxt;
      g_q    <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(b_nxt)));
      tick_q <= tick_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign g     = g_q;
  assign b_mon = b_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_gray_cnt.sv
// Bench for gray_cnt: vector table on a DIV=1 instance, model-driven sequence on a
// DIV=3 instance, and an asynchronous reset check; expectations flow through queues.
module tb_gray_cnt;
  import gray_pkg::*;

  typedef struct {
    logic       clr, load, en, up;
    logic [2:0] lv;
    logic [2:0] b, g;
    logic       tick, wrap;
  } vec_t;

  typedef struct {
    logic [2:0] b, g;
    logic       tick, wrap;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       clr_a = 0, load_a = 0, en_a = 0, up_a = 1;
  logic [2:0] lv_a = '0;
  logic [2:0] g_a, b_a;
  logic       tick_a, wrap_a;

  logic       clr_b = 0, load_b = 0, en_b = 0, up_b = 1;
  logic [2:0] lv_b = '0;
  logic [2:0] g_b, b_b;
  logic       tick_b, wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[$];

  logic [2:0] gray3 [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  int m_b = 0;
  int m_pre = 0;

  always #5 clk = ~clk;

  gray_cnt #(.WIDTH(3), .DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(lv_a), .g(g_a), .b_mon(b_a), .tick(tick_a), .wrap(wrap_a));

  gray_cnt #(.WIDTH(3), .DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .en(en_b), .up(up_b), .load(load_b),
    .load_val(lv_b), .g(g_b), .b_mon(b_b), .tick(tick_b), .wrap(wrap_b));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input exp_t e, input logic [2:0] g, input logic [2:0] b,
                          input logic t, input logic w);
    chk({e.name, ".b_mon"}, b, e.b);
    chk({e.name, ".g"}, g, e.g);
    chk({e.name, ".tick"}, t, e.tick);
    chk({e.name, ".wrap"}, w, e.wrap);
    chk({e.name, ".gtb"}, int'(3'(gray2bin(GRAY_MAX_WIDTH'(g)))), b);
  endtask

  function automatic vec_t mk(input logic clr, load, en, up, input logic [2:0] lv,
                              input logic [2:0] b, g, input logic t, w);
    vec_t v;
    v.clr = clr; v.load = load; v.en = en; v.up = up; v.lv = lv;
    v.b = b; v.g = g; v.tick = t; v.wrap = w;
    return v;
  endfunction

  task automatic apply_a(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    clr_a = v.clr; load_a = v.load; en_a = v.en; up_a = v.up; lv_a = v.lv;
    e.b = v.b; e.g = v.g; e.tick = v.tick; e.wrap = v.wrap; e.name = name;
    qa.push_back(e);
    @(posedge clk);
    #1;
    if (qa.size() == 0) chk("qa_empty", 1, 0);
    else sb_check(qa.pop_front(), g_a, b_a, tick_a, wrap_a);
  endtask

  task automatic apply_b(input logic en, input logic up, input string name, output logic t);
    exp_t e;
    logic et, ew;
    @(negedge clk);
    en_b = en; up_b = up;
    et = 1'b0; ew = 1'b0;
    if (en) begin
      if (m_pre == 2) begin
        m_pre = 0;
        if (up && m_b == 7) begin
`ifndef GRAY_CNT_SAT_EN
          m_b = 0; et = 1'b1; ew = 1'b1;
`endif
        end else if (!up && m_b == 0) begin
`ifndef GRAY_CNT_SAT_EN
          m_b = 7; et = 1'b1; ew = 1'b1;
`endif
        end else begin
          m_b = up ? m_b + 1 : m_b - 1;
          et = 1'b1;
        end
      end else begin
        m_pre++;
      end
    end
    e.b = 3'(m_b); e.g = gray3[m_b]; e.tick = et; e.wrap = ew; e.name = name;
    qb.push_back(e);
    @(posedge clk);
    #1;
    t = tick_b;
    if (qb.size() == 0) chk("qb_empty", 1, 0);
    else sb_check(qb.pop_front(), g_b, b_b, tick_b, wrap_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t;
    int   tick_idx[$];
    logic [1:0] b_en_pat [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    logic       b_up_pat [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

`ifdef GRAY_CNT_SAT_EN
    tbl.push_back(mk(0, 1, 1, 1, 3'd6, 3'd6, 3'b101, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3'd0, 3'd6, 3'b101, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 3'd0, 3'd0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3'd0, 3'd0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3'd2, 3'd2, 3'b011, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd0, 3'd2, 3'b011, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 3'd3, 3'd0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 1, 0));
`else
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd2, 3'b011, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd3, 3'b010, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd4, 3'b110, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd5, 3'b111, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd6, 3'b101, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd7, 3'b100, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3'd0, 3'd7, 3'b100, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 3'd0, 3'd6, 3'b101, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 3'd5, 3'd5, 3'b111, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd0, 3'd5, 3'b111, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 3'd3, 3'd0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3'd7, 3'd7, 3'b100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 3'd0, 3'd0, 3'b000, 1, 1));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.b_mon", b_a, 0);
    chk("rst.g", g_a, 0);
    chk("rst.tick", tick_a, 0);
    chk("rst.wrap", wrap_a, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_a(tbl[i], $sformatf("vec%0d", i));
    end
    apply_a(mk(0, 0, 0, 1, 3'd0, b_a, g_a, 0, 0), "idle_a");

    // Prescaler: en pause mid-period and direction change mid-period
    for (int i = 0; i < 12; i++) begin
      apply_b(b_en_pat[i][0], b_up_pat[i], $sformatf("pre%0d", i), t);
      if (t) tick_idx.push_back(i);
    end
    chk("pre.tick_count", tick_idx.size(), 3);
    if (tick_idx.size() >= 2) begin
      chk("pre.first_tick", tick_idx[0], 2);
      chk("pre.tick_gap", tick_idx[1] - tick_idx[0], 5);
    end
    en_b = 1'b0;

    // Async reset while counting
    apply_a(mk(0, 1, 0, 1, 3'd5, 3'd5, 3'b111, 0, 0), "ld5");
    apply_a(mk(0, 0, 1, 1, 3'd0, 3'd6, 3'b101, 1, 0), "to6");
    @(negedge clk);
    en_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.b_mon", b_a, 0);
    chk("arst.g", g_a, 0);
    chk("arst.tick", tick_a, 0);
    chk("arst.wrap", wrap_a, 0);
    chk("arst.b_mon_b", b_b, 0);
    m_b = 0; m_pre = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_a(mk(0, 0, 1, 1, 3'd0, 3'd1, 3'b001, 1, 0), "resume");
    apply_b(1'b1, 1'b1, "resume_b0", t);
    apply_b(1'b1, 1'b1, "resume_b1", t);
    apply_b(1'b1, 1'b1, "resume_b2", t);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_cnt.md
# gray_cnt

Parameterised up/down Gray-code counter that generates the Gray stimulus consumed by the downstream Gray-to-binary converter (`gtb3bit`). It keeps a binary count internally and registers the matching Gray code on every step, with an enable prescaler, synchronous clear and load. A binary monitor output lets the converter's result be checked against it cycle by cycle.

## Interface
- `WIDTH`, 3: counter and code width in bits, 2..16.
- `DIV`, 1: prescale ratio. The count steps once every `DIV` enabled cycles, 1..256.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clr` in 1: synchronous clear of the count and the prescaler.
- `en` in 1: count enable; it also gates the prescaler.
- `up` in 1: direction, 1 = increment, 0 = decrement.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in WIDTH: binary value to load.
- `g` out WIDTH: registered Gray code, equal to bin2gray(`b_mon`) at all times.
- `b_mon` out WIDTH: registered binary count.
- `tick` out 1: one-cycle pulse in the cycle after the count changes by a step.
- `wrap` out 1: one-cycle pulse in the cycle after the count rolls over (max→0 counting up, 0→max counting down).

## Operation
- Reset values: `b_mon`=0, `g`=0, `tick`=0, `wrap`=0, prescaler=0.
- Per-edge priority is `clr` > `load` > step.
- `clr`: count and prescaler go to 0. `tick` and `wrap` are 0.
- `load`: count takes `load_val` and the prescaler goes to 0. `tick` and `wrap` are 0. `en` is ignored in that cycle.
- Prescaler `pre` has width max(1, clog2(DIV)).
  - When `en`=1 and `pre`≠DIV-1, `pre` increments.
  - When `en`=1 and `pre`=DIV-1, `pre` returns to 0 and the count steps.
  - When `en`=0, `pre` holds.
  - With DIV=1, every enabled cycle is a step.
- Step: binary count ±1 modulo 2^WIDTH. `g` is registered from the next binary value, g = b ^ (b>>1), so Gray and binary never skew.
- Exactly one bit of `g` changes per step, including across a wrap.
- Toggling `up` mid-prescale does not reset `pre`. The new direction applies at the next step.
- `rst_n` asserted mid-operation clears everything immediately, regardless of `clk`. Deassertion is synchronised externally.

## Timing
- Step latency is one cycle. With `en` high at edge k (and `pre`=DIV-1), `g`, `b_mon` and `tick` update after edge k.
- `load` and `clr` also have one-cycle latency.
- `tick` and `wrap` are registered, high for exactly one cycle per event, and aligned with the new count.
- No combinational path from inputs to outputs.

## Configuration
- `GRAY_CNT_SAT_EN` defined: the counter saturates instead of wrapping.
  - A step up at 2^WIDTH-1, or down at 0, holds the count.
  - `tick`=0 and `wrap`=0 for that step; `pre` still recycles.
- Not defined: modulo wrap as described under Operation, with `wrap` and `tick` both pulsed.

## Structure
- Shared package `gray_pkg` holds:
  - `bin2gray` and `gray2bin` functions (the bench uses `gray2bin` as its reference model);
  - limits `GRAY_MAX_WIDTH`=16 and `GRAY_MAX_DIV`=256.
- One sub-module, `gray_cnt_prescale`: the `DIV` enable divider with `en` and sync-clear inputs and a `step` output.
- Count, Gray register and flags live in `gray_cnt`.

## Test plan
- WIDTH=3, DIV=1, `en`=1, `up`=1 for 8 cycles from reset → `g` = 001,011,010,110,111,101,100,000. `tick` is high every cycle; `wrap` is high only on the final 100→000 step.
- From 0 with `up`=0, one enabled cycle → `b_mon`=7, `g`=100, `wrap`=1. A downstream `gtb3bit` output must equal `b_mon` on every cycle.
- `load`=1 with `load_val`=5 and `en`=1 → next cycle `b_mon`=5, `g`=111, `tick`=0. `clr`=1 together with `load`=1 → `b_mon`=0.
- DIV=3 with `en` held high → `tick` every 3rd cycle. Drop `en` for 2 cycles mid-prescale → the step is delayed by exactly 2 cycles.
- `rst_n` pulled low while `b_mon`=6 → `g`, `b_mon`, `tick`, `wrap` are 0 before the next clock edge. Counting resumes from 0 after release.
- With `GRAY_CNT_SAT_EN`, counting up from 6 for 3 steps → 7 then holds at 7 (`g`=100). `wrap` is never asserted, and `tick` fires only on the 6→7 step.
